multi_req_ack: RTL

MULTI_REQ_ACK -- requirements
Module: multi_req_ack

---
 rtl/multi_req_ack_pkg.sv | 19 +
 rtl/multi_req_ack_if.sv | 34 +++
 rtl/multi_req_ack_rr_arb.sv | 34 +++
 rtl/multi_req_ack.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/multi_req_ack_pkg.sv
// Shared types and limits for the multi-channel req/ack block.
// FSM state encoding plus parameter bounds and an index-width helper.
package multi_req_ack_pkg;

   localparam int ACK_LAT_MIN = 2;
   localparam int ACK_LAT_MAX = 16;
   localparam int NUM_CH_MAX  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_req_ack_if.sv
// Request/acknowledge bundle between a requester and multi_req_ack.
// The slave modport is the block side; master is the requester side.
interface multi_req_ack_if #(
   parameter int NUM_CH = 4
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] ovf_clr;
   logic [NUM_CH-1:0] ack;
   logic              busy;
   logic [IW-1:0]     gnt_ch;
   logic [NUM_CH-1:0] ovf;

   modport master (
      output req,
      output ovf_clr,
      input  ack,
      input  busy,
      input  gnt_ch,
      input  ovf
   );

   modport slave (
      input  req,
      input  ovf_clr,
      output ack,
      output busy,
      output gnt_ch,
      output ovf
   );

endinterface

// File: rtl/multi_req_ack_rr_arb.sv
// Round-robin picker: first pending channel at or after ptr, wrapping.
// ptr holds the channel one past the last grant (0 after reset).
module rr_arb
   import multi_req_ack_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]        pending,
   input  logic [idx_w(NUM_CH)-1:0] ptr,
   output logic                     gnt_valid,
   output logic [idx_w(NUM_CH)-1:0] gnt_idx
);

   localparam int IW = idx_w(NUM_CH);

   logic found;
   int   c;

   always_comb begin
      gnt_valid = |pending;
      gnt_idx   = '0;
      found     = 1'b0;
      c         = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         c = int'(ptr) + k;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!found && |(pending & (NUM_CH'(1) << c))) begin
            found   = 1'b1;
            gnt_idx = IW'(c);
         end
      end
   end

endmodule

// File: rtl/multi_req_ack.sv
// Multi-channel req/ack server: rise detect, round-robin grant, fixed ack latency.
// Define MULTI_REQ_ACK_SVA_EN to compile in the protocol assertions.
module multi_req_ack
   import multi_req_ack_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int ACK_LAT = 2
) (
   input logic            clk,
   input logic            rst_n,
   multi_req_ack_if.slave bus
);

   localparam int IW = idx_w(NUM_CH);
   localparam int CW = 4;

   if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
      $fatal(1, "multi_req_ack: NUM_CH %0d out of range", NUM_CH);
   end
   if (ACK_LAT < ACK_LAT_MIN || ACK_LAT > ACK_LAT_MAX) begin : g_bad_ack_lat
      $fatal(1, "multi_req_ack: ACK_LAT %0d out of range", ACK_LAT);
   end

   state_t            state;
   state_t            state_n;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_n;
   logic [NUM_CH-1:0] req_q;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] gnt_mask;
   logic [NUM_CH-1:0] ack_q;
   logic [NUM_CH-1:0] ack_n;
   logic [NUM_CH-1:0] ovf_q;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     gnt_q;
   logic [IW-1:0]     gnt_idx;
   logic              gnt_valid;
   logic              grant;
   logic              busy;

   rr_arb #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .pending   (pending),
      .ptr       (ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign rise     = bus.req & ~req_q;
   assign grant    = (state == IDLE) && gnt_valid;
   assign gnt_mask = grant ? (NUM_CH'(1) << gnt_idx) : '0;
   assign busy     = (state != IDLE);

   assign bus.ack    = ack_q;
   assign bus.busy   = busy;
   assign bus.gnt_ch = gnt_q;
   assign bus.ovf    = ovf_q;

   // WAIT spans ACK_LAT-2 cycles, so the counter starts at ACK_LAT-3.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ack_n   = '0;
      unique case (state)
         IDLE: begin
            if (gnt_valid) begin
               if (ACK_LAT == ACK_LAT_MIN) begin
                  state_n = ACK;
                  ack_n   = NUM_CH'(1) << gnt_idx;
               end else begin
                  state_n = WAIT;
                  cnt_n   = CW'((ACK_LAT > 2) ? ACK_LAT - 3 : 0);
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_n = ACK;
               ack_n   = NUM_CH'(1) << gnt_q;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ACK:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ack_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ack_q <= ack_n;
      end
   end

   // A granted bit clears before the same-edge rise re-sets it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         pending <= '0;
         ovf_q   <= '0;
      end else begin
         req_q   <= bus.req;
         pending <= (pending & ~gnt_mask) | rise;
         ovf_q   <= (ovf_q & ~bus.ovf_clr)
                  | (rise & pending & ~gnt_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         gnt_q <= '0;
      end else if (grant) begin
         gnt_q <= gnt_idx;
         ptr   <= (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

`ifdef MULTI_REQ_ACK_SVA_EN
   a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(ack_q));

   a_ack_state: assert property (@(posedge clk) disable iff (!rst_n)
      (|ack_q) |-> (state == ACK));

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lat
      a_lat: assert property (@(posedge clk) disable iff (!rst_n)
         ($rose(bus.req[i]) && state == IDLE && pending == '0
          && (rise & ~(NUM_CH'(1) << i)) == '0)
         |-> ##ACK_LAT $rose(ack_q[i]));
   end

   a_busy_fall: assert property (@(posedge clk) disable iff (!rst_n)
      $fell(busy) |-> $past(|ack_q));
`endif

endmodule
